// File: rtl/add_cla_pipe_if.sv
// Operand/result bundle for add_cla_pipe.
// Handshake: a beat moves on a rising edge when valid & ready are both high; a
// producer holds valid and its data until that edge; ready never depends on valid.
interface add_cla_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             SUB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             OVF;

    modport slave (
        input  in_valid, A, B, Cin, SUB, out_ready,
        output in_ready, out_valid, S, Cout, OVF
    );

    modport master (
        output in_valid, A, B, Cin, SUB, out_ready,
        input  in_ready, out_valid, S, Cout, OVF
    );
endinterface

// File: rtl/add_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group is
// resolved per stage, the group carry is registered, the whole pipe stalls together.
module add_cla_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic         CLK,
    input  logic         RST,
    add_cla_pipe_if.slave bus
);
    localparam int NSTG = WIDTH / GROUP;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [GROUP-1:0] grp_t;

    word_t           a_q   [NSTG];
    word_t           b_q   [NSTG];
    word_t           sum_q [NSTG];
    logic [NSTG-1:0] v_q;
    logic [NSTG-1:0] c_q;
    logic            ovf_q;

    word_t           a_d   [NSTG];
    word_t           b_d   [NSTG];
    word_t           sum_d [NSTG];
    logic [NSTG-1:0] v_d;
    logic [NSTG-1:0] c_d;
    logic            ovf_d;

    word_t           sum_in [NSTG];
    logic [NSTG-1:0] c_in;
    grp_t            ga [NSTG];
    grp_t            gb [NSTG];
    logic [GROUP:0]  cy [NSTG];
    logic            en;

    // Every carry is a flat sum of products of g/p/c0; nothing ripples through sum bits.
    function automatic logic [GROUP:0] lookahead(input grp_t g, input grp_t p, input logic c0);
        logic [GROUP:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < GROUP; i++) begin
            term = c0;
            for (int k = 0; k <= i; k++) term = term & p[k];
            c[i+1] = term;
            for (int k = 0; k <= i; k++) begin
                term = g[k];
                for (int m = k + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    assign en = ~v_q[NSTG-1] | bus.out_ready;

    // Stage inputs: stage 0 takes the bus, later stages take their predecessor.
    always_comb begin
        c_in      = '0;
        v_d       = '0;
        a_d[0]    = bus.A;
        b_d[0]    = bus.B ^ {WIDTH{bus.SUB}};
        sum_in[0] = '0;
        c_in[0]   = bus.Cin;
        v_d[0]    = bus.in_valid;
        for (int j = 1; j < NSTG; j++) begin
            a_d[j]    = a_q[j-1];
            b_d[j]    = b_q[j-1];
            sum_in[j] = sum_q[j-1];
            c_in[j]   = c_q[j-1];
            v_d[j]    = v_q[j-1];
        end
    end

    always_comb begin
        ovf_d = 1'b0;
        c_d   = '0;
        for (int j = 0; j < NSTG; j++) begin
            ga[j]    = a_d[j][j*GROUP +: GROUP];
            gb[j]    = b_d[j][j*GROUP +: GROUP];
            cy[j]    = lookahead(ga[j] & gb[j], ga[j] | gb[j], c_in[j]);
            sum_d[j] = sum_in[j];
            sum_d[j][j*GROUP +: GROUP] = ga[j] ^ gb[j] ^ cy[j][GROUP-1:0];
            c_d[j]   = cy[j][GROUP];
        end
        ovf_d = cy[NSTG-1][GROUP] ^ cy[NSTG-1][GROUP-1];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int j = 0; j < NSTG; j++) begin
                a_q[j]   <= '0;
                b_q[j]   <= '0;
                sum_q[j] <= '0;
            end
        end else if (en) begin
            v_q   <= v_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int j = 0; j < NSTG; j++) begin
                a_q[j]   <= a_d[j];
                b_q[j]   <= b_d[j];
                sum_q[j] <= sum_d[j];
            end
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = v_q[NSTG-1];
    assign bus.S         = sum_q[NSTG-1];
    assign bus.Cout      = c_q[NSTG-1];
    assign bus.OVF       = ovf_q;
endmodule

// File: tb/tb_add_cla_pipe.sv
// Bench for add_cla_pipe: directed cases on a 16/4 instance plus random streams
// on 16/4, 4/1, 32/8 and 8/8 instances, all scored against an arithmetic model.
module tb_add_cla_pipe;
    localparam int W    = 16;
    localparam int G    = 4;
    localparam int NSTG = W / G;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    add_cla_pipe_if #(.WIDTH(W)) bus ();
    add_cla_pipe #(.WIDTH(W), .GROUP(G)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [W+1:0]  exp_q[$];
    logic          rand_ready = 1'b0;
    logic          aux_go = 1'b0;
    int            aux_left = 3;

    // {OVF, Cout, S}: plain (W+1)-bit addition, overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W-1:0] bx;
        logic [W:0]   full;
        logic         ovf;
        bx   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, cin};
        ovf  = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
        return {ovf, full};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input logic [W+1:0] e);
        int t;
        t = 0;
        bus.A = a; bus.B = b; bus.Cin = cin; bus.SUB = sub; bus.in_valid = 1'b1;
        @(negedge CLK);
        while (!bus.in_ready && t < 200) begin
            t++;
            @(negedge CLK);
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stuck at 0, expected 1 within 200 cycles");
        end else begin
            exp_q.push_back(e);
        end
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        send_exp(a, b, cin, sub, model(a, b, cin, sub));
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge CLK);
            t++;
        end
        #1;
        check(tag, exp_q.size(), 0);
    endtask

    // Monitor: everything is sampled on the falling edge, half a cycle from any change.
    initial begin
        logic         held;
        logic [W+1:0] held_val;
        logic [W+1:0] e;
        held = 1'b0;
        held_val = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                held = 1'b0;
            end else begin
                check("in_ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
                if (held) check("stall_hold", {bus.OVF, bus.Cout, bus.S}, held_val);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_result: got 0x%0h, expected no result",
                                 {bus.OVF, bus.Cout, bus.S});
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {bus.OVF, bus.Cout, bus.S}, e);
                    end
                end
                held     = bus.out_valid && !bus.out_ready;
                held_val = {bus.OVF, bus.Cout, bus.S};
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.SUB = 1'b0;
        bus.out_ready = 1'b1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_S", bus.S, '0);
        check("reset_Cout", bus.Cout, 1'b0);
        check("reset_OVF", bus.OVF, 1'b0);
        check("reset_in_ready", bus.in_ready, 1'b1);

        // Latency: acceptance edge counts as the first of NSTG edges.
        bus.A = 16'h1234; bus.B = 16'h4321; bus.Cin = 1'b0; bus.SUB = 1'b0;
        bus.in_valid = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 16'h5555});
        @(negedge CLK);
        check("latency_accept", bus.in_ready, 1'b1);
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
        for (int e = 1; e < NSTG; e++) begin
            check("latency_early", bus.out_valid, 1'b0);
            @(posedge CLK);
            #1;
        end
        check("latency_valid", bus.out_valid, 1'b1);
        drain("drain_add");

        send_exp(16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0000});
        send_exp(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
        send_exp(16'h0005, 16'h0003, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0002});
        send_exp(16'h0003, 16'h0005, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        send_exp(16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        drain("drain_directed");

        // Backpressure: six back-to-back operands with a three-cycle output stall.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            end
            begin
                repeat (3) @(posedge CLK);
                #1;
                bus.out_ready = 1'b0;
                repeat (2) @(posedge CLK);
                @(negedge CLK);
                check("stall_out_valid", bus.out_valid, 1'b1);
                check("stall_in_ready", bus.in_ready, 1'b0);
                @(posedge CLK);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain("drain_stall");

        // Reset with three operands in flight: none of them may emerge.
        for (int i = 0; i < 3; i++)
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        RST = 1'b1;
        exp_q.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_S", bus.S, '0);
        check("midrst_in_ready", bus.in_ready, 1'b1);
        repeat (12) @(posedge CLK);
        #1;

        // Random stream with random bubbles and random downstream stalls.
        rand_ready = 1'b1;
        aux_go = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK);
                #1;
            end
        end
        rand_ready = 1'b0;
        @(posedge CLK);
        #2;
        bus.out_ready = 1'b1;
        drain("drain_random");

        begin
            int t;
            t = 0;
            while (aux_left != 0 && t < 20000) begin
                @(posedge CLK);
                t++;
            end
            check("aux_streams_done", aux_left, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    for (genvar k = 0; k < 3; k++) begin : g_aux
        localparam int AW = (k == 0) ? 4 : (k == 1) ? 32 : 8;
        localparam int AG = (k == 0) ? 1 : 8;

        add_cla_pipe_if #(.WIDTH(AW)) abus ();
        add_cla_pipe #(.WIDTH(AW), .GROUP(AG)) adut (.CLK(CLK), .RST(RST), .bus(abus));

        logic [AW+1:0] aq[$];

        function automatic logic [AW+1:0] amodel(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                                 input logic cin, input logic sub);
            logic [AW-1:0] bx;
            logic [AW:0]   full;
            logic          ovf;
            bx   = sub ? ~b : b;
            full = {1'b0, a} + {1'b0, bx} + {{AW{1'b0}}, cin};
            ovf  = (a[AW-1] == bx[AW-1]) && (full[AW-1] != a[AW-1]);
            return {ovf, full};
        endfunction

        initial begin
            int t;
            abus.in_valid = 1'b0; abus.A = '0; abus.B = '0; abus.Cin = 1'b0; abus.SUB = 1'b0;
            abus.out_ready = 1'b1;
            while (!aux_go) @(posedge CLK);
            #1;
            for (int i = 0; i < 2000; i++) begin
                abus.A = AW'($urandom);
                abus.B = AW'($urandom);
                abus.Cin = 1'($urandom);
                abus.SUB = 1'($urandom);
                abus.in_valid = ($urandom_range(0, 3) != 0);
                abus.out_ready = ($urandom_range(0, 3) != 0);
                @(negedge CLK);
                if (abus.in_valid && abus.in_ready)
                    aq.push_back(amodel(abus.A, abus.B, abus.Cin, abus.SUB));
                @(posedge CLK);
                #1;
            end
            abus.in_valid = 1'b0;
            abus.out_ready = 1'b1;
            t = 0;
            while (aq.size() != 0 && t < 1000) begin
                @(posedge CLK);
                t++;
            end
            #1;
            check($sformatf("aux%0d_drain", k), aq.size(), 0);
            aux_left--;
        end

        initial begin
            logic [AW+1:0] e;
            forever begin
                @(negedge CLK);
                if (!RST && abus.out_valid && abus.out_ready) begin
                    if (aq.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL aux%0d_unexpected: got 0x%0h, expected no result",
                                 k, {abus.OVF, abus.Cout, abus.S});
                    end else begin
                        e = aq.pop_front();
                        check($sformatf("aux%0d_result", k), {abus.OVF, abus.Cout, abus.S}, e);
                    end
                end
            end
        end
    end
endmodule

// File: doc/add_cla_pipe.md
Name: add_cla_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the lab datapath.
- WIDTH-bit operands are split into GROUP-bit carry-lookahead groups, with one group resolved per pipeline stage and the inter-group carry registered.
- Uses valid/ready handshakes on input and output with full backpressure; one operation per cycle when not stalled.
- Adds a subtract mode and a signed-overflow flag.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a positive multiple of GROUP.
- GROUP, 4, bits per lookahead group (1..8); number of stages NSTG = WIDTH/GROUP.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in to bit 0; drive 1 for plain subtract.
- SUB  input  1  0 = A+B+Cin; 1 = A+~B+Cin.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- S  output  WIDTH  sum/difference.
- Cout  output  1  carry out of the MSB; in SUB mode, 1 = no borrow.
- OVF  output  1  signed overflow = carry into MSB XOR Cout.

Behaviour:
- Effective operand is Bx = B XOR {WIDTH{SUB}}. Carry c0 = Cin in both modes.
- Group j (bits j*GROUP .. j*GROUP+GROUP-1) computes bit generate g = a&b and propagate p = a|b. The group carry chain is fully lookahead within the group: no rippling through full-adder outputs. Sum bit = a^b^c.
- Stage j holds:
  - a valid bit;
  - the registered sum bits of groups 0..j;
  - the registered carry out of group j;
  - the unprocessed upper operand bits (A and Bx groups j+1..NSTG-1), skewed forward;
  - the carry into the MSB, captured in the last stage for OVF.
- Global advance: en = ~out_valid | out_ready. in_ready = en (combinational from out_valid/out_ready only, never from in_valid).
- Transfer on a rising edge:
  - Input accepted when in_valid & in_ready.
  - When en = 1, every stage loads from its predecessor; stage 0 loads the input with valid = in_valid.
  - When en = 0, all stages hold, including data and valid bits.
- Latency: a transfer accepted at edge k gives out_valid = 1 after edge k+NSTG-1, i.e. S is visible in the cycle following NSTG rising edges from acceptance, assuming no stall. Throughput is 1 per cycle.
- S, Cout and OVF are the last-stage registers. They stay stable while out_valid & ~out_ready.
- Bubbles (in_valid = 0 while en = 1) propagate as invalid slots. Bubbles are not collapsed.
- Outputs while out_valid = 0 are don't-care for checking, but remain registered values.
- Reset: on an RST edge, all valid bits = 0, S = 0, Cout = 0, OVF = 0. in_ready = 1 in the following cycle. Reset mid-operation discards all in-flight operations; none emerge afterwards. RST has priority over transfer.
- Wrap-around: unsigned results are taken modulo 2^WIDTH, with the carry reported on Cout.
- NSTG = 1 (WIDTH = GROUP): degenerates to a single registered stage with latency 1.
- Simultaneous out_ready and in_valid with a full pipeline: both a result and an input transfer occur on the same edge.

Test Plan:
- Add, no stall (WIDTH=16, GROUP=4): A=0x1234, B=0x4321, SUB=0, Cin=0, out_ready=1 -> S=0x5555, Cout=0, OVF=0, out_valid exactly 4 edges after acceptance.
- Full carry chain: A=0xFFFF, B=0x0000, Cin=1 -> S=0x0000, Cout=1, OVF=0. Then A=0x7FFF, B=0x0001, Cin=0 -> S=0x8000, Cout=0, OVF=1.
- Subtract: A=0x0005, B=0x0003, SUB=1, Cin=1 -> S=0x0002, Cout=1. Then A=0x0003, B=0x0005 -> S=0xFFFE, Cout=0, OVF=0. Then A=0x8000, B=0x0001 -> S=0x7FFF, OVF=1.
- Backpressure: stream 6 operands back-to-back, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 exactly while out_valid & ~out_ready; no result lost, duplicated or reordered; S is stable during the stall.
- Reset mid-flight: accept 3 operands, assert RST for 1 edge -> out_valid=0 and S=0 after the edge; none of the 3 results ever appears; in_ready=1.
- Random compare over WIDTH∈{4,16,32}, GROUP∈{1,4,8}: 10k random A, B, Cin, SUB with random out_ready/in_valid -> every output equals the reference model {Cout,S} = A + Bx + Cin and matches its OVF, in order.
